// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. It compares two WIDTH-bit operands
//   CHUNK bits per cycle, starting with the most significant chunk. The
//   compare can be unsigned or two's-complement signed.
//
//   Optional feature macro: SEQ_CMP_EARLY_EXIT_EN
//     defined   : the compare finishes on the first chunk that differs, so
//                 latency is 1..NUM_CHUNKS cycles
//     undefined : constant time; done always follows NUM_CHUNKS cycles
//                 after the start edge
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset (takes priority over start)
//   start        compare request, sampled only while idle
//   signed_mode  1 = two's-complement compare, 0 = unsigned (latched with start)
//   a, b         operands, latched with start
//   busy         high while a compare is in progress
//   done         one-cycle pulse when eq/lt/gt become valid
//   eq, lt, gt   result flags, held until the next accepted start or reset
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK-1:0] SIGN_BIT = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IDX_W-1:0] idx_q;
`ifndef SEQ_CMP_EARLY_EXIT_EN
  logic             decided_q;
`endif

  logic [CHUNK-1:0] chunk_a_c;
  logic [CHUNK-1:0] chunk_b_c;
  logic [CHUNK-1:0] sign_flip_c;
  logic             top_c;
  logic             last_c;
  logic             lt_c;
  logic             gt_c;
  int unsigned      shift_c;

  // Current chunk compare. A signed top chunk becomes an unsigned compare
  // once its sign bits are inverted (offset-binary ordering).
  always_comb begin
    top_c       = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    last_c      = (idx_q == '0);
    shift_c     = CHUNK * 32'(idx_q);
    sign_flip_c = (signed_q && top_c) ? SIGN_BIT : '0;
    chunk_a_c   = CHUNK'(a_q >> shift_c) ^ sign_flip_c;
    chunk_b_c   = CHUNK'(b_q >> shift_c) ^ sign_flip_c;
    lt_c        = (chunk_a_c < chunk_b_c);
    gt_c        = (chunk_a_c > chunk_b_c);
  end

  // Control FSM, operand latches and registered result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
      decided_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            signed_q  <= signed_mode;
            idx_q     <= IDX_W'(NUM_CHUNKS - 1);
            busy      <= 1'b1;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            decided_q <= 1'b0;
`endif
            state     <= COMPARE;
          end
        end

        COMPARE: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
          if (lt_c || gt_c) begin
            lt    <= lt_c;
            gt    <= gt_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (last_c) begin
            eq    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
`else
          // First difference wins; later chunks are walked only for timing.
          if (!decided_q && (lt_c || gt_c)) begin
            lt        <= lt_c;
            gt        <= gt_c;
            decided_q <= 1'b1;
          end
          if (last_c) begin
            if (!decided_q && !lt_c && !gt_c) begin
              eq <= 1'b1;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//   Directed, table-driven bench for seq_magnitude_comparator (WIDTH=32,
//   CHUNK=8). Expected latencies follow SEQ_CMP_EARLY_EXIT_EN when the
//   macro is defined for the build.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  localparam int unsigned NUM_CHUNKS = 4;
  localparam int          MAX_WAIT   = 40;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        eq;
  logic        lt;
  logic        gt;

  int tests;
  int fails;

  seq_magnitude_comparator #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .eq         (eq),
    .lt         (lt),
    .gt         (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vb;
    logic        sgn;
    logic        exp_eq;
    logic        exp_lt;
    logic        exp_gt;
    int          lat_ee;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int lat_ee);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    return lat_ee;
`else
    return (lat_ee > 0) ? int'(NUM_CHUNKS) : int'(NUM_CHUNKS);
`endif
  endfunction

  // Present operands with start high; returns #1 after the capturing edge.
  task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic sgn);
    a           = va;
    b           = vb;
    signed_mode = sgn;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
  endtask

  // Waits for done, counting busy samples, then checks latency and flags.
  task automatic wait_done(input string name, input int lat,
                           input logic e_eq, input logic e_lt, input logic e_gt);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < MAX_WAIT) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, n, lat);
    check({name, " busy_cycles"}, bc, lat);
    check({name, " busy_low_at_done"}, int'(busy), 0);
    check({name, " eq"}, int'(eq), int'(e_eq));
    check({name, " lt"}, int'(lt), int'(e_lt));
    check({name, " gt"}, int'(gt), int'(e_gt));
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;

    vecs[0] = '{"zeros_eq",      32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[1] = '{"mid_word_gt",   32'h00008000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[2] = '{"signed_min_lt", 32'h80000000, 32'h7fffffff, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[3] = '{"unsigned_gt",   32'h80000000, 32'h7fffffff, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{"signed_neg_gt", 32'hf0000000, 32'he0000000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[5] = '{"lsb_gt",        32'h11111111, 32'h11111110, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[6] = '{"lsb_lt",        32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    vecs[7] = '{"signed_eq",     32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    vecs[8] = '{"minus1_lt_0",   32'hffffffff, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[9] = '{"low_chunk_uns", 32'h0000ff00, 32'h00007f00, 1'b1, 1'b0, 1'b0, 1'b1, 3};

    // Reset state, with start held to show reset dominates.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset flags", int'({eq, lt, gt}), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Table-driven compares.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      launch(vecs[i].va, vecs[i].vb, vecs[i].sgn);
      check({vecs[i].name, " busy_after_start"}, int'(busy), 1);
      check({vecs[i].name, " flags_cleared"}, int'({eq, lt, gt}), 0);
      wait_done(vecs[i].name, exp_lat(vecs[i].lat_ee),
                vecs[i].exp_eq, vecs[i].exp_lt, vecs[i].exp_gt);
      @(posedge clk);
      #1;
      check({vecs[i].name, " done_one_cycle"}, int'(done), 0);
      check({vecs[i].name, " flags_held"}, int'({eq, lt, gt}),
            int'({vecs[i].exp_eq, vecs[i].exp_lt, vecs[i].exp_gt}));
    end

    // Back-to-back: start raised in the done cycle is taken with no bubble.
    @(negedge clk);
    launch(32'h11111111, 32'h11111110, 1'b0);
    wait_done("b2b_first", int'(NUM_CHUNKS), 1'b0, 1'b0, 1'b1);
    check("b2b done_high", int'(done), 1);
    launch(32'haaaaaaaa, 32'haaaaaaaa, 1'b0);
    check("b2b done_dropped", int'(done), 0);
    check("b2b busy_rose", int'(busy), 1);
    check("b2b flags_cleared", int'({eq, lt, gt}), 0);
    wait_done("b2b_second", int'(NUM_CHUNKS), 1'b1, 1'b0, 1'b0);

    // start while busy is ignored; the first operands decide the result.
    @(negedge clk);
    launch(32'h00000001, 32'h00000002, 1'b0);
    launch(32'hffffffff, 32'hffffffff, 1'b0);
    wait_done("busy_ignore", int'(NUM_CHUNKS) - 1, 1'b0, 1'b1, 1'b0);

    // Reset at edge t+2 aborts the compare with no later done pulse.
    @(negedge clk);
    launch(32'h00000001, 32'h00000002, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort flags", int'({eq, lt, gt}), 0);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1 || busy === 1'b1) seen++;
      end
      check("abort no_done_after", seen, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised multi-cycle magnitude comparator. Returns equal / less-than / greater-than for two WIDTH-bit operands, unsigned or two's-complement signed.
- Evaluates CHUNK bits per cycle, most significant chunk first, with a start/busy/done handshake.
- Successor to the single-cycle 32-bit equality comparator. Used where wide operands would otherwise make the compare path timing-critical.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NUM_CHUNKS (localparam), WIDTH/CHUNK, number of compare cycles in the worst case.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only while idle.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when a result becomes valid.
- eq  output  1  A == B.
- lt  output  1  A < B.
- gt  output  1  A > B.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, eq, lt, gt all 0; latched operands and chunk index cleared. Reset dominates start.
- Reset mid-compare aborts the compare. All outputs are 0 after the edge, and no done pulse follows.
- FSM states: IDLE, COMPARE.
- IDLE, start=1 at edge t:
  - latch a, b and signed_mode; idx = NUM_CHUNKS-1.
  - busy=1 and done=0 after edge t.
  - eq/lt/gt are cleared to 0 at this edge.
- COMPARE, one chunk per cycle, bits [idx*CHUNK +: CHUNK] of the latched operands:
  - Top chunk (idx = NUM_CHUNKS-1) with signed_mode=1: compared as signed CHUNK-bit values.
  - All other chunks, and all chunks with signed_mode=0: compared unsigned.
  - Chunks differ: set lt or gt accordingly, then terminate. Termination follows the early-exit rule under Optional Feature.
  - Chunks equal and idx>0: idx decrements; stay in COMPARE.
  - Chunks equal and idx==0: eq=1; terminate.
- Terminate: at that edge go to IDLE, busy=0, done=1 for exactly one cycle.
  - eq/lt/gt stay stable until the next accepted start or reset.
  - Exactly one of eq/lt/gt is 1 after any completed compare.
- Latency (start edge t to done high):
  - full compare: done after edge t+NUM_CHUNKS;
  - early exit on chunk k (k=1 is the MSB chunk): done after edge t+k.
- start while busy=1: ignored; latched operands unchanged.
- start during the done cycle: accepted, because the FSM is already in IDLE.
  - done drops and busy rises at that edge.
  - Back-to-back throughput is one compare per NUM_CHUNKS cycles (worst case) with no bubble.
- Operand inputs a/b may change freely after the start edge.
- NUM_CHUNKS=1 (CHUNK=WIDTH): every compare finishes in one cycle.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: the FSM terminates on the first differing chunk; latency is data-dependent (1..NUM_CHUNKS).
- Undefined: constant-time operation.
  - The first difference is recorded in a sticky "decided" flag.
  - Lower chunks are still walked but cannot change the result.
  - done always arrives after edge t+NUM_CHUNKS.

Test Plan (WIDTH=32, CHUNK=8; each case run with and without SEQ_CMP_EARLY_EXIT_EN):
- Equal zeros: a=00000000, b=00000000, unsigned, start at edge t -> done after t+4; eq=1, lt=0, gt=0; busy high for exactly 4 cycles.
- Mid-word difference: a=00008000, b=00000000, unsigned -> gt=1; done after t+3 with EN, after t+4 without.
- Signed vs unsigned: a=80000000, b=7fffffff.
  - signed_mode=1 -> lt=1, done after t+1 (EN).
  - signed_mode=0 -> gt=1.
  - a=f0000000, b=e0000000 signed -> gt=1.
- LSB difference: a=11111111, b=11111110 -> gt=1, eq=0, done after t+4 in both builds.
  - Then a=aaaaaaaa, b=aaaaaaaa, with start asserted in the done cycle -> accepted with no idle cycle; eq=1 after 4 more cycles.
- Busy and reset:
  - start with a=00000001, b=00000002; one cycle later pulse start again with a=b=ffffffff -> second start ignored; lt=1.
  - Repeat the first compare and assert reset at edge t+2 -> busy/done/eq/lt/gt all 0 after that edge; no done pulse afterwards.
